glitch_sweep_ctrl: RTL

Sequencer that drives the glitch engine's delay and width registers automatically through a 2-D parameter grid, instead of stepping them by hand with buttons. On `start` it latches sweep bounds, arms the glitch engine once per attempt, waits for the engine's completion pulse, and applies a cooldown. It then repeats the point or advances delay (inner loop) and width (outer loop) until the grid is exhausted. It sits between the front-panel/UART configuration registers and the glitch engine, and owns `delay_out`/`width_out` while `busy` is high.

---
 rtl/glitch_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/glitch_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// glitch_sweep_ctrl
//
// Walks the glitch engine's delay/width registers through a 2-D grid. Delay is
// the inner loop and width is the outer loop. Each grid point gets `repeats`
// attempts. An attempt arms the engine, waits for its completion pulse, then
// idles for `cooldown`+1 cycles before the next attempt.
//
// Optional feature macro: SWEEP_TIMEOUT_EN
//   defined   -> RUN watchdog. After TIMEOUT_CYCLES cycles without glitch_done
//                the attempt is closed as if the engine had finished, and
//                timeout_count increments (saturating).
//   undefined -> no watchdog. RUN waits indefinitely and timeout_count stays 0.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   start, abort        : begin a sweep (sampled in IDLE) / return to IDLE
//   delay_min/max/step  : inner-loop bounds and step (latched on start)
//   width_min/max/step  : outer-loop bounds and step (latched on start)
//   repeats, cooldown   : attempts per point and idle cycles between attempts
//   glitch_done         : one-cycle completion pulse from the glitch engine
//   arm                 : high while an attempt is outstanding (state RUN)
//   delay_out/width_out : current grid point
//   busy                : sweep in progress (state != IDLE)
//   done                : one-cycle pulse on normal completion
//   attempt_count       : attempts completed in the current/last sweep
//   timeout_count       : attempts closed by the watchdog
// ---------------------------------------------------------------------------
module glitch_sweep_ctrl #(
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] delay_min,
    input  logic [W-1:0] delay_max,
    input  logic [W-1:0] delay_step,
    input  logic [W-1:0] width_min,
    input  logic [W-1:0] width_max,
    input  logic [W-1:0] width_step,
    input  logic [7:0]   repeats,
    input  logic [15:0]  cooldown,
    input  logic         glitch_done,
    output logic         arm,
    output logic [W-1:0] delay_out,
    output logic [W-1:0] width_out,
    output logic         busy,
    output logic         done,
    output logic [31:0]  attempt_count,
    output logic [15:0]  timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    state_t       state_r, state_nxt_s;

    // Sweep configuration captured at start
    logic [W-1:0] dmin_r, dmax_r, dstep_r;
    logic [W-1:0] wmin_r, wmax_r, wstep_r;
    logic [7:0]   reps_r;
    logic [15:0]  cool_r;

    // Sweep progress
    logic [15:0]  cnt_r;
    logic [7:0]   rep_r;
    logic [W-1:0] delay_r, width_r;
    logic [31:0]  attempt_r;
    logic [15:0]  tmo_r;
    logic         done_r;

    // Transition strobes produced by the next-state logic
    logic         latch_s, finish_s, timeout_s;
    logic         adv_rep_s, adv_delay_s, adv_width_s, end_s;
    logic         wd_hit_s;
    logic         arm_s, busy_s;

    // One extra bit so a step past 2^W-1 compares as "beyond max" instead of wrapping
    logic [W:0]   d_next_s, w_next_s;
    logic         rep_more_s;

    assign d_next_s   = {1'b0, delay_r} + {1'b0, dstep_r};
    assign w_next_s   = {1'b0, width_r} + {1'b0, wstep_r};
    assign rep_more_s = ({1'b0, rep_r} + 9'd1) < {1'b0, reps_r};

`ifdef SWEEP_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_r;

    // Watchdog counts RUN cycles; RUN is always entered from IDLE or COOL, so it restarts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r <= 32'd0;
        end else if (state_r != ST_RUN) begin
            wd_r <= 32'd0;
        end else begin
            wd_r <= wd_r + 32'd1;
        end
    end

    assign wd_hit_s = (wd_r == WD_LIMIT);
`else
    // No watchdog in this build; the parameter is kept so both builds share one port/parameter list
    assign wd_hit_s = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and transition strobes; abort overrides everything
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        finish_s    = 1'b0;
        timeout_s   = 1'b0;
        adv_rep_s   = 1'b0;
        adv_delay_s = 1'b0;
        adv_width_s = 1'b0;
        end_s       = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                        latch_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (glitch_done) begin
                        state_nxt_s = ST_COOL;
                        finish_s    = 1'b1;
                    end else if (wd_hit_s) begin
                        state_nxt_s = ST_COOL;
                        finish_s    = 1'b1;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_COOL: begin
                    if (cnt_r != 16'd0) begin
                        state_nxt_s = ST_COOL;
                    end else if (rep_more_s) begin
                        state_nxt_s = ST_RUN;
                        adv_rep_s   = 1'b1;
                    end else if (d_next_s <= {1'b0, dmax_r}) begin
                        state_nxt_s = ST_RUN;
                        adv_delay_s = 1'b1;
                    end else if (w_next_s <= {1'b0, wmax_r}) begin
                        state_nxt_s = ST_RUN;
                        adv_width_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        end_s       = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        arm_s  = (state_r == ST_RUN);
        busy_s = (state_r != ST_IDLE);
    end

    // Datapath: configuration capture, grid stepping and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            dmin_r    <= '0;
            dmax_r    <= '0;
            dstep_r   <= '0;
            wmin_r    <= '0;
            wmax_r    <= '0;
            wstep_r   <= '0;
            reps_r    <= 8'd0;
            cool_r    <= 16'd0;
            cnt_r     <= 16'd0;
            rep_r     <= 8'd0;
            delay_r   <= '0;
            width_r   <= '0;
            attempt_r <= 32'd0;
            tmo_r     <= 16'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= end_s;
            if (latch_s) begin
                // Zero step / zero repeats would stall or skip the grid, so promote them to 1
                dmin_r    <= delay_min;
                dmax_r    <= delay_max;
                dstep_r   <= (delay_step == '0) ? ONE_W : delay_step;
                wmin_r    <= width_min;
                wmax_r    <= width_max;
                wstep_r   <= (width_step == '0) ? ONE_W : width_step;
                reps_r    <= (repeats == 8'd0) ? 8'd1 : repeats;
                cool_r    <= cooldown;
                cnt_r     <= 16'd0;
                rep_r     <= 8'd0;
                delay_r   <= delay_min;
                width_r   <= width_min;
                attempt_r <= 32'd0;
                tmo_r     <= 16'd0;
            end else if (finish_s) begin
                cnt_r     <= cool_r;
                attempt_r <= attempt_r + 32'd1;
                if (timeout_s && (tmo_r != 16'hFFFF)) begin
                    tmo_r <= tmo_r + 16'd1;
                end else begin
                    tmo_r <= tmo_r;
                end
            end else if ((state_r == ST_COOL) && (cnt_r != 16'd0) && !abort) begin
                cnt_r <= cnt_r - 16'd1;
            end else if (adv_rep_s) begin
                rep_r <= rep_r + 8'd1;
            end else if (adv_delay_s) begin
                rep_r   <= 8'd0;
                delay_r <= d_next_s[W-1:0];
            end else if (adv_width_s) begin
                rep_r   <= 8'd0;
                delay_r <= dmin_r;
                width_r <= w_next_s[W-1:0];
            end else if (end_s) begin
                rep_r   <= 8'd0;
                delay_r <= dmin_r;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign arm           = arm_s;
    assign busy          = busy_s;
    assign delay_out     = delay_r;
    assign width_out     = width_r;
    assign done          = done_r;
    assign attempt_count = attempt_r;
    assign timeout_count = tmo_r;

endmodule
